// File: rtl/ctrl_soma_matriz_if.sv
// ============================================================================
// ctrl_soma_matriz_if
// Start/done handshake, memory bus and adder operand bundle for the matrix
// adder sequencer. MATSUM_OVF_FLAG_EN adds the ovf flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ctrl_soma_matriz_if #(
    parameter int ELEM_W = 8,
    parameter int N_ELEM = 25,
    parameter int ADDR_W = 8
);
    logic                       start;
    logic [ADDR_W-1:0]          base_a;
    logic [ADDR_W-1:0]          base_b;
    logic [ADDR_W-1:0]          base_r;
    logic                       busy;
    logic                       done;
    logic [ADDR_W-1:0]          mem_addr;
    logic                       mem_rd;
    logic [ELEM_W-1:0]          mem_rdata;
    logic                       mem_wr;
    logic [ELEM_W-1:0]          mem_wdata;
    logic [N_ELEM*ELEM_W-1:0]   mat_a;
    logic [N_ELEM*ELEM_W-1:0]   mat_b;
    logic [N_ELEM*ELEM_W-1:0]   mat_res;
`ifdef MATSUM_OVF_FLAG_EN
    logic                       ovf;
`endif

    modport master (
        input  start, base_a, base_b, base_r, mem_rdata, mat_res,
        output busy, done, mem_addr, mem_rd, mem_wr, mem_wdata, mat_a, mat_b
`ifdef MATSUM_OVF_FLAG_EN
        , output ovf
`endif
    );

    modport slave (
        output start, base_a, base_b, base_r, mem_rdata, mat_res,
        input  busy, done, mem_addr, mem_rd, mem_wr, mem_wdata, mat_a, mat_b
`ifdef MATSUM_OVF_FLAG_EN
        , input ovf
`endif
    );
endinterface

`default_nettype wire

// File: rtl/ctrl_soma_matriz.sv
// ============================================================================
// ctrl_soma_matriz
// Sequencer for the 5x5 element-wise matrix adder: loads A and B from memory,
// captures the adder result and writes it back. Optional macro
// MATSUM_OVF_FLAG_EN adds a sticky unsigned-carry flag (ovf).
// Revision: 1.0
// ============================================================================
`default_nettype none

module ctrl_soma_matriz #(
    parameter int ELEM_W = 8,
    parameter int N_ELEM = 25,
    parameter int ADDR_W = 8
) (
    input  wire logic            clk,
    input  wire logic            reset,
    ctrl_soma_matriz_if.master   bus
);
    localparam int IDX_W = $clog2(N_ELEM);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_EXEC   = 3'd3,
        S_STORE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                     r_state;
    logic [ADDR_W-1:0]          r_base_a;
    logic [ADDR_W-1:0]          r_base_b;
    logic [ADDR_W-1:0]          r_base_r;
    logic [ADDR_W-1:0]          r_mem_addr;
    logic [IDX_W-1:0]           r_idx;
    logic [IDX_W-1:0]           r_rd_idx;
    logic                       r_rd_pend;
    logic                       r_rd_b;
    logic                       r_wphase;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_mem_rd;
    logic                       r_mem_wr;
    logic [ELEM_W-1:0]          r_mem_wdata;
    logic [N_ELEM*ELEM_W-1:0]   r_mat_a;
    logic [N_ELEM*ELEM_W-1:0]   r_mat_b;
    logic [N_ELEM*ELEM_W-1:0]   r_res;

    logic [IDX_W-1:0]           w_idx_next;
    logic [ADDR_W-1:0]          w_off_next;
    logic                       w_last;

    assign w_idx_next = r_idx + IDX_W'(1);
    assign w_off_next = ADDR_W'(w_idx_next);
    assign w_last     = (r_idx == IDX_W'(N_ELEM - 1));

`ifdef MATSUM_OVF_FLAG_EN
    logic r_ovf;
    logic w_carry;

    always_comb begin
        w_carry = 1'b0;
        for (int k = 0; k < N_ELEM; k++) begin
            if (bus.mat_res[k*ELEM_W +: ELEM_W] < r_mat_a[k*ELEM_W +: ELEM_W])
                w_carry = 1'b1;
        end
    end

    assign bus.ovf = r_ovf;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_base_a    <= '0;
            r_base_b    <= '0;
            r_base_r    <= '0;
            r_mem_addr  <= '0;
            r_idx       <= '0;
            r_rd_idx    <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_b      <= 1'b0;
            r_wphase    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_wdata <= '0;
            r_mat_a     <= '0;
            r_mat_b     <= '0;
            r_res       <= '0;
`ifdef MATSUM_OVF_FLAG_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            // Read data arrives one cycle after the strobe; remember where it goes.
            r_rd_pend <= r_mem_rd;
            r_rd_idx  <= r_idx;
            r_rd_b    <= (r_state == S_LOAD_B);
            if (r_rd_pend) begin
                if (r_rd_b)
                    r_mat_b[r_rd_idx*ELEM_W +: ELEM_W] <= bus.mem_rdata;
                else
                    r_mat_a[r_rd_idx*ELEM_W +: ELEM_W] <= bus.mem_rdata;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_base_a   <= bus.base_a;
                        r_base_b   <= bus.base_b;
                        r_base_r   <= bus.base_r;
                        r_idx      <= '0;
                        r_busy     <= 1'b1;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= bus.base_a;
                        r_state    <= S_LOAD_A;
`ifdef MATSUM_OVF_FLAG_EN
                        r_ovf      <= 1'b0;
`endif
                    end
                end
                S_LOAD_A: begin
                    if (w_last) begin
                        r_idx      <= '0;
                        r_mem_addr <= r_base_b;
                        r_state    <= S_LOAD_B;
                    end else begin
                        r_idx      <= w_idx_next;
                        r_mem_addr <= r_base_a + w_off_next;
                    end
                end
                S_LOAD_B: begin
                    if (w_last) begin
                        r_idx    <= '0;
                        r_mem_rd <= 1'b0;
                        r_state  <= S_EXEC;
                    end else begin
                        r_idx      <= w_idx_next;
                        r_mem_addr <= r_base_b + w_off_next;
                    end
                end
                S_EXEC: begin
                    r_wphase <= 1'b0;
                    r_state  <= S_STORE;
                end
                S_STORE: begin
                    if (!r_wphase) begin
                        // Operands are complete now; freeze the sum before writing.
                        r_res       <= bus.mat_res;
                        r_mem_wr    <= 1'b1;
                        r_mem_addr  <= r_base_r;
                        r_mem_wdata <= bus.mat_res[ELEM_W-1:0];
                        r_idx       <= '0;
                        r_wphase    <= 1'b1;
`ifdef MATSUM_OVF_FLAG_EN
                        r_ovf       <= r_ovf | w_carry;
`endif
                    end else if (w_last) begin
                        r_mem_wr <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_idx       <= w_idx_next;
                        r_mem_addr  <= r_base_r + w_off_next;
                        r_mem_wdata <= r_res[w_idx_next*ELEM_W +: ELEM_W];
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_rd    = r_mem_rd;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mat_a     = r_mat_a;
    assign bus.mat_b     = r_mat_b;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_soma_matriz.sv
// ============================================================================
// tb_ctrl_soma_matriz
// Self-checking bench: memory model, behavioural adder and a snapshot-based
// reference of the expected memory image after each operation.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ctrl_soma_matriz;
    localparam int EW = 8;
    localparam int NE = 25;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ctrl_soma_matriz_if #(.ELEM_W(EW), .N_ELEM(NE), .ADDR_W(AW)) bus ();

    ctrl_soma_matriz #(.ELEM_W(EW), .N_ELEM(NE), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural adder
    logic [NE*EW-1:0] res_w;
    always_comb begin
        res_w = '0;
        for (int k = 0; k < NE; k++)
            res_w[k*EW +: EW] = bus.mat_a[k*EW +: EW] + bus.mat_b[k*EW +: EW];
    end
    assign bus.mat_res = res_w;

    // Synchronous memory; load_req copies a whole preset image in one edge
    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic       load_req = 1'b0;
    logic [7:0] rdata = '0;
    assign bus.mem_rdata = rdata;

    always @(posedge clk) begin
        if (load_req)
            mem <= img;
        else if (bus.mem_wr)
            mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd)
            rdata <= mem[bus.mem_addr];
    end

    logic [7:0] rd_q [$];
    int done_cnt = 0;
    int both_cnt = 0;
    always @(negedge clk) begin
        if (bus.mem_rd) rd_q.push_back(bus.mem_addr);
        if (bus.mem_rd && bus.mem_wr) both_cnt++;
        if (bus.done) done_cnt++;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [7:0] snap [256];
    logic [7:0] expm [256];
    logic       exp_ovf;

    task automatic load_img();
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    task automatic compute_ref(input int ba, input int bb, input int br, input int nwr);
        int a, b, r;
        for (int i = 0; i < 256; i++) begin
            snap[i] = mem[i];
            expm[i] = mem[i];
        end
        exp_ovf = 1'b0;
        for (int k = 0; k < NE; k++) begin
            a = snap[(ba + k) % 256];
            b = snap[(bb + k) % 256];
            r = (a + b) % 256;
            if (k < nwr) expm[(br + k) % 256] = 8'(r);
            if (r < a) exp_ovf = 1'b1;
        end
    endtask

    task automatic check_mem(input string tag);
        int nbad = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== expm[i]) nbad++;
        check({tag, ":mem_bad"}, nbad, 0);
    endtask

    task automatic check_reads(input string tag, input int rd0, input int ba, input int bb);
        int nbad = 0;
        check({tag, ":rd_count"}, rd_q.size() - rd0, 2 * NE);
        if (rd_q.size() - rd0 >= 2 * NE) begin
            for (int k = 0; k < NE; k++) begin
                if (rd_q[rd0 + k] !== 8'((ba + k) % 256)) nbad++;
                if (rd_q[rd0 + NE + k] !== 8'((bb + k) % 256)) nbad++;
            end
        end
        check({tag, ":rd_addr_bad"}, nbad, 0);
    endtask

    task automatic run_op(input int ba, input int bb, input int br, input int glitch,
                          input string tag);
        int rd0, d0, lat;
        rd0 = rd_q.size();
        d0  = done_cnt;
        compute_ref(ba, bb, br, NE);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.base_a = 8'(ba);
        bus.base_b = 8'(bb);
        bus.base_r = 8'(br);
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == glitch) begin
                bus.start  = 1'b1;
                bus.base_a = 8'($urandom);
                bus.base_b = 8'($urandom);
                bus.base_r = 8'($urandom);
            end else if (c == glitch + 1) begin
                bus.start = 1'b0;
            end
            if (c == 1) check({tag, ":busy_c1"}, bus.busy, 1);
            if (bus.done) begin
                lat = c;
                check({tag, ":busy_at_done"}, bus.busy, 0);
                break;
            end
        end
        check({tag, ":latency"}, lat, 3 * NE + 3);
        repeat (3) @(negedge clk);
        check({tag, ":done_pulses"}, done_cnt - d0, 1);
        check({tag, ":idle_busy"}, bus.busy, 0);
        check_mem(tag);
        check_reads(tag, rd0, ba, bb);
`ifdef MATSUM_OVF_FLAG_EN
        check({tag, ":ovf"}, bus.ovf, exp_ovf);
`endif
    endtask

    initial begin
        int d0, lat1, lat2;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.base_a = '0;
        bus.base_b = '0;
        bus.base_r = '0;
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst:busy", bus.busy, 0);
        check("rst:done", bus.done, 0);
        check("rst:mem_rd", bus.mem_rd, 0);
        check("rst:mem_wr", bus.mem_wr, 0);
        check("rst:mem_addr", bus.mem_addr, 0);
        check("rst:mem_wdata", bus.mem_wdata, 0);
        check("rst:mat_zero", (bus.mat_a == '0) && (bus.mat_b == '0), 1);
`ifdef MATSUM_OVF_FLAG_EN
        check("rst:ovf", bus.ovf, 0);
`endif
        reset = 1'b0;

        // T1: A[k]=k, B[k]=2k
        for (int k = 0; k < NE; k++) begin
            img[k]        = 8'(k);
            img[8'h20 + k] = 8'(2 * k);
        end
        load_img();
        run_op(8'h00, 8'h20, 8'h40, 0, "t1");
        check("t1:r5", mem[8'h45], 8'd15);
        check("t1:r24", mem[8'h58], 8'd72);
        check("t1:mat_a3", bus.mat_a[3*EW +: EW], 8'd3);

        // T2: wrapping sums, then small sums
        for (int k = 0; k < NE; k++) begin
            img[k]        = 8'hF0;
            img[8'h20 + k] = 8'h20;
        end
        load_img();
        run_op(8'h00, 8'h20, 8'h40, 0, "t2wrap");
        check("t2:r0", mem[8'h40], 8'h10);
`ifdef MATSUM_OVF_FLAG_EN
        check("t2:ovf_set", bus.ovf, 1);
`endif
        for (int k = 0; k < NE; k++) begin
            img[k]        = 8'h01;
            img[8'h20 + k] = 8'h01;
        end
        load_img();
        run_op(8'h00, 8'h20, 8'h40, 0, "t2small");

        // T3: read addresses wrap past 0xFF
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        load_img();
        run_op(8'hF0, 8'h30, 8'h80, 0, "t3");

        // T4: result written over A in place
        run_op(8'h10, 8'h60, 8'h10, 0, "t4");

        // T5: start pulse during LOAD_B is ignored
        run_op(8'h00, 8'h20, 8'h40, 35, "t5glitch");

        // T5: start held high gives back-to-back operations
        compute_ref(8'h00, 8'h20, 8'h40, NE);
        d0 = done_cnt;
        lat1 = 0;
        lat2 = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.base_a = 8'h00;
        bus.base_b = 8'h20;
        bus.base_r = 8'h40;
        @(posedge clk);
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (bus.done) begin
                if (lat1 == 0) lat1 = c;
                else lat2 = c;
            end
            if (lat1 != 0 && c == lat1 + 1) check("t5b:idle_gap", bus.busy, 0);
            if (lat1 != 0 && c == lat1 + 2) begin
                check("t5b:restart", bus.busy, 1);
                bus.start = 1'b0;
            end
            if (lat2 != 0) break;
        end
        bus.start = 1'b0;
        check("t5b:lat1", lat1, 78);
        check("t5b:lat2", lat2, 157);
        repeat (3) @(negedge clk);
        check("t5b:done_pulses", done_cnt - d0, 2);
        check_mem("t5b");

        // T6: reset during STORE k=10 aborts the write sequence
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        load_img();
        compute_ref(8'h00, 8'h20, 8'h40, 10);
        d0 = done_cnt;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.base_a = 8'h00;
        bus.base_b = 8'h20;
        bus.base_r = 8'h40;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (63) @(negedge clk);
        check("t6:wr_before", bus.mem_wr, 1);
        check("t6:addr_before", bus.mem_addr, 8'h4A);
        reset = 1'b1;
        #1;
        check("t6:wr_after", bus.mem_wr, 0);
        check("t6:busy_after", bus.busy, 0);
        check("t6:addr_after", bus.mem_addr, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("t6:no_done", done_cnt - d0, 0);
        check_mem("t6");
        run_op(8'h00, 8'h20, 8'h40, 0, "t6after");

        // Randomised operations with arbitrary, possibly overlapping regions
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
            load_img();
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), 0, $sformatf("rnd%0d", n));
        end

        check("proto:rd_wr_overlap", both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
